// File: rtl/fp_mul_pkg.sv
// Shared definitions for the FP32 multiplier normalize/round back end:
// operand classes, result flag positions, exponent limits and stage registers.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ZERO   = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_cls_t;

    // Bit positions within out_state
    localparam int unsigned ST_ZERO = 4;
    localparam int unsigned ST_NAN  = 3;
    localparam int unsigned ST_INF  = 2;
    localparam int unsigned ST_OVF  = 1;
    localparam int unsigned ST_UNF  = 0;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef struct packed {
        logic               valid;
        logic               sign;
        logic signed [10:0] e;
        logic [23:0]        mant;
        logic               guard;
        logic               sticky;
        fp_cls_t            cls_a;
        fp_cls_t            cls_b;
    } s1_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] c;
        logic [4:0]  state;
    } s2_reg_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit mantissa; a carry-out renormalizes to 1.0.
module fp_round_rne (
    input  logic [23:0] mant_i,
    input  logic        guard_i,
    input  logic        sticky_i,
    output logic [23:0] mant_o,
    output logic        carry_o
);

    logic        inc;
    logic [24:0] sum;

    assign inc     = guard_i & (sticky_i | mant_i[0]);
    assign sum     = {1'b0, mant_i} + {24'b0, inc};
    assign carry_o = sum[24];
    assign mant_o  = sum[24] ? 24'h80_0000 : sum[23:0];

endmodule

// File: rtl/fp_mul_norm.sv
// Two-stage FP32 product normalizer: S1 normalizes, S2 rounds, range-checks and packs.
// Define FP_MUL_NORM_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp_mul_norm
    import fp_mul_pkg::*;
#(
    parameter logic [31:0] QNAN_PATTERN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp_sum,
    input  logic [47:0] in_prod,
    input  logic [1:0]  in_cls_a,
    input  logic [1:0]  in_cls_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic [4:0]  out_state
);

    localparam logic signed [10:0] BiasM1 = 11'(BIAS - 1);
    localparam logic signed [10:0] Bias   = 11'(BIAS);
    localparam logic signed [10:0] EMax   = 11'(EXP_MAX);

    s1_reg_t s1_q, s1_d;
    s2_reg_t s2_q, s2_d;

    logic               s2_en;
    logic [23:0]        mant_r;
    logic               carry_r;
    logic signed [10:0] e_r;
    logic               is_nan, is_inf, is_zero;
    logic [31:0]        res_c;
    logic [4:0]         res_st;

    // S2 can take a new value when empty or when its result is leaving
    assign s2_en    = !s2_q.valid | out_ready;
    assign in_ready = s2_en | !s1_q.valid;

    always_comb begin
        s1_d = s1_q;
        if (in_ready) begin
            s1_d.valid = in_valid;
            if (in_valid) begin
                s1_d.sign  = in_sign;
                s1_d.cls_a = fp_cls_t'(in_cls_a);
                s1_d.cls_b = fp_cls_t'(in_cls_b);
                if (in_prod[47]) begin
                    s1_d.mant   = in_prod[47:24];
                    s1_d.guard  = in_prod[23];
                    s1_d.sticky = |in_prod[22:0];
                    s1_d.e      = $signed({1'b0, in_exp_sum}) - BiasM1;
                end else begin
                    s1_d.mant   = in_prod[46:23];
                    s1_d.guard  = in_prod[22];
                    s1_d.sticky = |in_prod[21:0];
                    s1_d.e      = $signed({1'b0, in_exp_sum}) - Bias;
                end
            end
        end
    end

`ifdef FP_MUL_NORM_RNE_EN
    fp_round_rne u_round (
        .mant_i   (s1_q.mant),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .mant_o   (mant_r),
        .carry_o  (carry_r)
    );
`else
    assign mant_r  = s1_q.mant;
    assign carry_r = 1'b0;
`endif

    assign e_r = s1_q.e + $signed({10'b0, carry_r});

    assign is_nan  = (s1_q.cls_a == NAN) | (s1_q.cls_b == NAN) |
                     ((s1_q.cls_a == INF) & (s1_q.cls_b == ZERO)) |
                     ((s1_q.cls_a == ZERO) & (s1_q.cls_b == INF));
    assign is_inf  = (s1_q.cls_a == INF) | (s1_q.cls_b == INF);
    assign is_zero = (s1_q.cls_a == ZERO) | (s1_q.cls_b == ZERO);

    always_comb begin
        res_c  = '0;
        res_st = '0;
        if (is_nan) begin
            res_c          = QNAN_PATTERN;
            res_st[ST_NAN] = 1'b1;
        end else if (is_inf) begin
            res_c          = {s1_q.sign, 8'hFF, 23'b0};
            res_st[ST_INF] = 1'b1;
        end else if (is_zero) begin
            res_c           = {s1_q.sign, 31'b0};
            res_st[ST_ZERO] = 1'b1;
        end else if (e_r >= EMax) begin
            res_c          = {s1_q.sign, 8'hFF, 23'b0};
            res_st[ST_OVF] = 1'b1;
        end else if (e_r <= 11'sd0) begin
            res_c          = {s1_q.sign, 31'b0};
            res_st[ST_UNF] = 1'b1;
        end else begin
            res_c = {s1_q.sign, e_r[7:0], mant_r[22:0]};
        end
    end

    always_comb begin
        s2_d = s2_q;
        if (s2_en) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.c     = res_c;
                s2_d.state = res_st;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign out_valid = s2_q.valid;
    assign out_c     = s2_q.c;
    assign out_state = s2_q.state;

endmodule

// File: tb/tb_fp_mul_norm.sv
// Directed bench for fp_mul_norm: expectations queued at acceptance, checked at delivery.
module tb_fp_mul_norm;

    localparam logic [1:0] CN = 2'd0, CZ = 2'd1, CI = 2'd2, CQ = 2'd3;

`ifdef FP_MUL_NORM_RNE_EN
    localparam logic [31:0] TieC   = 32'h4000_0002;
    localparam logic [31:0] CarryC = 32'h4080_0000;
`else
    localparam logic [31:0] TieC   = 32'h4000_0001;
    localparam logic [31:0] CarryC = 32'h407F_FFFF;
`endif

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_sign;
    logic [9:0]  in_exp_sum;
    logic [47:0] in_prod;
    logic [1:0]  in_cls_a, in_cls_b;
    logic        out_valid, out_ready;
    logic [31:0] out_c;
    logic [4:0]  out_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    fp_mul_norm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp_sum (in_exp_sum),
        .in_prod    (in_prod),
        .in_cls_a   (in_cls_a),
        .in_cls_b   (in_cls_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_state  (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one vector, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input logic s, input logic [9:0] ex, input logic [47:0] p,
                        input logic [1:0] ca, input logic [1:0] cb,
                        input logic [31:0] ec, input logic [4:0] es);
        int t = 0;
        in_sign = s; in_exp_sum = ex; in_prod = p; in_cls_a = ca; in_cls_b = cb;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t < 20) exp_q.push_back({ec, es});
        chk("accept_timeout", 64'(t < 20), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Delivery monitor: sampled mid-cycle, away from the rising edge
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out: observed %h/%b expected none", out_c, out_state);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                assert ({out_c, out_state} === exp_q[0]) else begin
                    n_err++;
                    $error("FAIL result%s: observed %h/%b expected %h/%b",
                           out_ready ? "" : "_stall", out_c, out_state,
                           exp_q[0][36:5], exp_q[0][4:0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int  i, cyc;
        logic acc, saw_block;
        logic [47:0] p;

        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp_sum = '0; in_prod = '0;
        in_cls_a = CN; in_cls_b = CN; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_c", 64'(out_c), 64'd0);
        chk("rst_out_state", 64'(out_state), 64'd0);
        #21 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1.5 * 2.0 with latency check
        send(1'b0, 10'd255, 48'h6000_0000_0000, CN, CN, 32'h4040_0000, 5'b00000);
        @(negedge clk); chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("lat_cycle2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        send(1'b0, 10'd254, 48'h8000_0180_0000, CN, CN, TieC, 5'b00000);
        send(1'b0, 10'd254, 48'hFFFF_FFFF_FFFF, CN, CN, CarryC, 5'b00000);
        send(1'b0, 10'd508, 48'h4000_0000_0000, CN, CN, 32'h7F80_0000, 5'b00010);
        send(1'b1, 10'd2,   48'h4000_0000_0000, CN, CN, 32'h8000_0000, 5'b00001);
        send(1'b0, 10'd381, 48'h4000_0000_0000, CN, CN, 32'h7F00_0000, 5'b00000);
        send(1'b0, 10'd382, 48'h4000_0000_0000, CN, CN, 32'h7F80_0000, 5'b00010);
        send(1'b0, 10'd128, 48'h4000_0000_0000, CN, CN, 32'h0080_0000, 5'b00000);
        send(1'b0, 10'd127, 48'h4000_0000_0000, CN, CN, 32'h0000_0000, 5'b00001);
        send(1'b0, 10'd255, 48'h4000_0000_0000, CQ, CN, 32'h7FC0_0000, 5'b01000);
        send(1'b0, 10'd255, 48'h4000_0000_0000, CI, CZ, 32'h7FC0_0000, 5'b01000);
        send(1'b1, 10'd255, 48'h4000_0000_0000, CI, CN, 32'hFF80_0000, 5'b00100);
        send(1'b0, 10'd255, 48'h4000_0000_0000, CI, CQ, 32'h7FC0_0000, 5'b01000);
        send(1'b1, 10'd508, 48'h4000_0000_0000, CN, CZ, 32'h8000_0000, 5'b10000);
        drain();

        // Backpressure: four back-to-back inputs, out_ready low for cycles 1..3
        i = 0; cyc = 0; saw_block = 1'b0;
        while (i < 4 && cyc < 50) begin
            out_ready = !(cyc >= 1 && cyc <= 3);
            p = 48'h4000_0000_0000 | (48'(i + 1) << 23);
            in_sign = 1'b0; in_exp_sum = 10'd255; in_prod = p; in_cls_a = CN; in_cls_b = CN;
            in_valid = 1'b1;
            #1;
            acc = in_ready;
            if (!acc) saw_block = 1'b1;
            if (acc) exp_q.push_back({32'h4000_0000 | 32'(i + 1), 5'b00000});
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_all_accepted", 64'(i), 64'd4);
        chk("bp_in_ready_low", 64'(saw_block), 64'd1);
        drain();

        // Reset with two results in flight
        send(1'b0, 10'd255, 48'h6000_0000_0000, CN, CN, 32'h4040_0000, 5'b00000);
        send(1'b1, 10'd255, 48'h6000_0000_0000, CN, CN, 32'hC040_0000, 5'b00000);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_c", 64'(out_c), 64'd0);
        chk("midrst_out_state", 64'(out_state), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(1'b0, 10'd254, 48'h8000_0000_0000, CN, CN, 32'h4000_0000, 5'b00000);
        @(negedge clk); chk("post_rst_lat1", 64'(out_valid), 64'd0);
        @(negedge clk); chk("post_rst_lat2", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        drain();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mul_norm.md
FP_MUL_NORM -- requirements
Module: fp_mul_norm

Interface
REQ-001 SHALL have parameter QNAN_PATTERN, default 32'h7FC0_0000, the value driven on out_c for NaN results.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, upstream product is valid.
REQ-005 SHALL have port in_ready, output, 1, block accepts the upstream product this cycle.
REQ-006 SHALL have port in_sign, input, 1, XOR of the operand signs.
REQ-007 SHALL have port in_exp_sum, input, 10, unsigned raw sum of the biased exponents (0..510).
REQ-008 SHALL have port in_prod, input, 48, raw 24x24 mantissa product with hidden ones included.
REQ-009 SHALL have ports in_cls_a and in_cls_b, input, 2 each, operand class (normal, zero, inf, nan).
REQ-010 SHALL have port out_valid, output, 1, result is valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port out_c, output, 32, FP32 result.
REQ-013 SHALL have port out_state, output, 5, one-hot flags {zero, nan, inf, overflow, underflow}; 0 means a normal result.

Function
REQ-014 SHALL transfer input on in_valid&in_ready and output on out_valid&out_ready.
REQ-015 SHALL be a 2-stage pipeline: S1 normalizes, S2 rounds, range-checks and packs; latency is exactly 2 cycles with no stall.
REQ-016 SHALL accept one operation per cycle while out_ready is high.
REQ-017 SHALL derive in_ready = !S2_valid | out_ready | !S1_valid, so a bubble in S1 or S2 is always fillable.
REQ-018 SHALL hold out_c, out_state and out_valid stable while out_valid & !out_ready; no result is dropped or duplicated, and order is preserved.
REQ-019 S1 SHALL normalize: if in_prod[47], mant=prod[47:24], guard=prod[23], sticky=|prod[22:0], e=exp_sum-126; else mant=prod[46:23], guard=prod[22], sticky=|prod[21:0], e=exp_sum-127.
REQ-020 S1 SHALL carry e as an 11-bit signed value, with no wrap-around.
REQ-021 S2 SHALL round per REQ-033; on mantissa carry-out, S2 SHALL set mant=24'h800000 and e=e+1.
REQ-022 Result selection SHALL apply in priority order: nan (either class is nan, or inf with zero) -> QNAN_PATTERN; inf -> {sign,8'hFF,0}; zero -> {sign,31'b0}; e>=255 -> {sign,8'hFF,0} with overflow flag; e<=0 -> {sign,31'b0} with underflow flag (no denormals); else {sign,e[7:0],mant[22:0]}.
REQ-023 Class information SHALL travel with its data through both stages.

Reset
REQ-024 While rst_n is low, out_valid, S1_valid and S2_valid SHALL be 0, out_c SHALL be 0 and out_state SHALL be 0, immediately and without a clock.
REQ-025 in_ready SHALL be 1 during and after reset.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight results; after deassertion the first accepted input appears 2 cycles later.

Configuration
REQ-027 Macro FP_MUL_NORM_RNE_EN SHALL select the rounding mode.
REQ-028 With FP_MUL_NORM_RNE_EN defined, S2 SHALL round to nearest even: increment when guard & (sticky | mant[0]).
REQ-029 Without FP_MUL_NORM_RNE_EN, S2 SHALL truncate; guard and sticky are ignored and the rounder is not instantiated.

Structure
REQ-030 Package fp_mul_pkg SHALL hold the class enum fp_cls_t (NORMAL, ZERO, INF, NAN), the state bit indices, BIAS=127, EXP_MAX=255 and the S1/S2 pipeline register struct typedefs.
REQ-031 The multiplier and the operand-classifier stages SHALL import fp_mul_pkg for shared definitions.
REQ-032 Stage logic SHALL be combinational between the registers, with one register bank per stage.
REQ-033 SHALL contain one sub-module, fp_round_rne: combinational, taking mant, guard and sticky and returning the rounded mantissa and carry.

Verification
REQ-034 Normal case: sign=0, exp_sum=255, prod=48'h6000_0000_0000, both classes normal -> out_c=32'h4040_0000 (1.5*2.0), out_state=0, 2 cycles after acceptance.
REQ-035 Rounding tie: exp_sum=254, prod=48'h8000_0180_0000 -> out_c=32'h4000_0002 with FP_MUL_NORM_RNE_EN defined; 32'h4000_0001 without it.
REQ-036 Range: exp_sum=508 -> out_c=32'h7F80_0000, overflow flag set; exp_sum=2 with sign=1 -> out_c=32'h8000_0000, underflow flag set.
REQ-037 Specials: cls_a=nan -> out_c=32'h7FC0_0000 with nan flag; cls_a=inf and cls_b=zero -> out_c=32'h7FC0_0000 with nan flag; cls_a=inf with cls_b normal and sign=1 -> out_c=32'hFF80_0000 with inf flag.
REQ-038 Backpressure: stream 4 back-to-back inputs with out_ready low for cycles 2-4 -> in_ready low once S1 and S2 are full, out_c stable while stalled, all 4 results delivered in order.
REQ-039 Reset mid-stream: assert rst_n low with 2 results in flight -> out_valid=0 immediately and no stale result appears after reset.
